// File: rtl/ddr4_cmd_packer.sv
// Packs the serial softMC instruction stream into PHASES-slot DDR4 DFI command
// bundles, decoding ACT/RD/WR per slot and expanding WAIT instructions into NOP slots.
module ddr4_cmd_packer #(
  parameter int ROW_WIDTH  = 17,
  parameter int BANK_WIDTH = 2,
  parameter int BG_WIDTH   = 2,
  parameter int CS_WIDTH   = 1,
  parameter int PHASES     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_instr,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PHASES*ROW_WIDTH-1:0]    dfi_address,
  output logic [PHASES*BANK_WIDTH-1:0]   dfi_bank,
  output logic [PHASES*BG_WIDTH-1:0]     dfi_bg,
  output logic [PHASES*CS_WIDTH-1:0]     dfi_cs_n,
  output logic [PHASES-1:0]              dfi_act_n,
  output logic [PHASES-1:0]              dfi_ras_n,
  output logic [PHASES-1:0]              dfi_cas_n,
  output logic [PHASES-1:0]              dfi_we_n,
  output logic [PHASES-1:0]              mc_rd,
  output logic [PHASES-1:0]              mc_wr
);

  localparam int PTR_W    = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int BANK_LSB = ROW_WIDTH;
  localparam int BG_LSB   = BANK_LSB + BANK_WIDTH;
  localparam int CS_LSB   = BG_LSB + BG_WIDTH;

  typedef enum logic {S_FILL, S_WAIT} state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  ptr;
  logic [15:0]       remaining;

  // Decoded slot for the instruction currently on in_instr.
  logic [ROW_WIDTH-1:0]  cmd_addr;
  logic [BANK_WIDTH-1:0] cmd_bank;
  logic [BG_WIDTH-1:0]   cmd_bg;
  logic [CS_WIDTH-1:0]   cmd_cs_n;
  logic                  cmd_act_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_rd, cmd_wr;

  logic        accept, cmd_accept, wait_accept, wait_step, wait_fill, wait_done;
  logic        flush_fire, ptr_last;
  logic [16:0] free;
  logic [15:0] wait_n;
  logic        unused_instr;

  // Row bits beyond ROW_WIDTH read as 1 when reused as ACT command pins.
  function automatic logic row_bit(input logic [ROW_WIDTH-1:0] a, input int idx);
    logic b;
    b = 1'b1;
    for (int i = 0; i < ROW_WIDTH; i++)
      if (i == idx) b = a[i];
    return b;
  endfunction

  assign cmd_addr     = in_instr[ROW_WIDTH-1:0];
  assign cmd_bank     = in_instr[BANK_LSB +: BANK_WIDTH];
  assign cmd_bg       = in_instr[BG_LSB +: BG_WIDTH];
  assign cmd_cs_n     = in_instr[CS_LSB +: CS_WIDTH];
  assign wait_n       = in_instr[15:0];
  assign unused_instr = ^in_instr;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    cmd_act_n = 1'b1;
    cmd_ras_n = in_instr[30];
    cmd_cas_n = in_instr[29];
    cmd_we_n  = in_instr[28];
    cmd_rd    = 1'b0;
    cmd_wr    = 1'b0;
    unique case (in_instr[30:28])
      3'b011: begin
        cmd_act_n = 1'b0;
        cmd_ras_n = row_bit(cmd_addr, 16);
        cmd_cas_n = row_bit(cmd_addr, 15);
        cmd_we_n  = row_bit(cmd_addr, 14);
      end
      3'b101:  cmd_rd = 1'b1;
      3'b100:  cmd_wr = 1'b1;
      default: ;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign cmd_accept  = accept && !in_instr[31];
  assign wait_accept = accept && in_instr[31] && (wait_n != 16'd0);
  assign free        = 17'(PHASES) - {{(17-PTR_W){1'b0}}, ptr};
  assign wait_step   = (state == S_WAIT) && !out_valid;
  assign wait_fill   = wait_step && ({1'b0, remaining} >= free);
  assign wait_done   = ({1'b0, remaining} == free);
  assign flush_fire  = flush && (state == S_FILL) && !out_valid && (ptr != '0) && !accept;
  assign ptr_last    = (ptr == PTR_W'(PHASES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_FILL: if (wait_accept) state_next = S_WAIT;
      S_WAIT: if (wait_step && (!wait_fill || wait_done)) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = !rst && (state == S_FILL) && !out_valid;
  end

  // Slots at or above ptr always hold NOP, so WAIT only advances ptr or completes the bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: slot registers are reset because the NOP encoding is a real bus value, not a don't-care.
      out_valid   <= 1'b0;
      ptr         <= '0;
      remaining   <= '0;
      dfi_address <= '0;
      dfi_bank    <= '0;
      dfi_bg      <= '0;
      dfi_cs_n    <= '1;
      dfi_act_n   <= '1;
      dfi_ras_n   <= '1;
      dfi_cas_n   <= '1;
      dfi_we_n    <= '1;
      mc_rd       <= '0;
      mc_wr       <= '0;
    end else begin
      // NOTE: nonblocking assignments so every register here samples pre-edge values.
      if (out_valid && out_ready) begin
        out_valid   <= 1'b0;
        dfi_address <= '0;
        dfi_bank    <= '0;
        dfi_bg      <= '0;
        dfi_cs_n    <= '1;
        dfi_act_n   <= '1;
        dfi_ras_n   <= '1;
        dfi_cas_n   <= '1;
        dfi_we_n    <= '1;
        mc_rd       <= '0;
        mc_wr       <= '0;
      end

      if (cmd_accept) begin
        for (int i = 0; i < PHASES; i++) begin
          if (ptr == PTR_W'(i)) begin
            dfi_address[i*ROW_WIDTH +: ROW_WIDTH]   <= cmd_addr;
            dfi_bank[i*BANK_WIDTH +: BANK_WIDTH]    <= cmd_bank;
            dfi_bg[i*BG_WIDTH +: BG_WIDTH]          <= cmd_bg;
            dfi_cs_n[i*CS_WIDTH +: CS_WIDTH]        <= cmd_cs_n;
            dfi_act_n[i] <= cmd_act_n;
            dfi_ras_n[i] <= cmd_ras_n;
            dfi_cas_n[i] <= cmd_cas_n;
            dfi_we_n[i]  <= cmd_we_n;
            mc_rd[i]     <= cmd_rd;
            mc_wr[i]     <= cmd_wr;
          end
        end
        if (ptr_last) begin
          ptr       <= '0;
          out_valid <= 1'b1;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end

      if (wait_accept) remaining <= wait_n;

      if (wait_step) begin
        if (wait_fill) begin
          remaining <= remaining - free[15:0];
          ptr       <= '0;
          out_valid <= 1'b1;
        end else begin
          ptr       <= ptr + remaining[PTR_W-1:0];
          remaining <= '0;
        end
      end

      if (flush_fire) begin
        ptr       <= '0;
        out_valid <= 1'b1;
      end
    end
  end

endmodule
